ram16x8_arbiter: RTL and testbench

Two-port access controller that shares a single `ram16x8` between an instruction-fetch requester (port 0, read-only, driven from the `program_counter` output) and a data requester (port 1, read/write). It arbitrates between the ports, registers the RAM control signals, and waits out the RAM's synchronous read latency. It returns read data with a one-cycle `done` pulse. It is the only block that drives the RAM's `we`, `addr` and `data_in`.

---
 rtl/ram16x8_arbiter.sv | 96 +++++++++
 tb/tb_ram16x8_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram16x8_arbiter.sv
// ram16x8_arbiter: shares one ram16x8 between an instruction-fetch port and a data port.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   p0_req/p0_addr -> p0_rdata/p0_done  read-only fetch port (address normally pc)
//   p1_req/p1_we/p1_addr/p1_wdata
//     -> p1_rdata/p1_done               read/write data port (write returns old contents)
//   ram_we/ram_addr/ram_wdata, ram_rdata registered RAM control, RAM read data
//   busy                                high whenever an access is in flight
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties);
// otherwise ties are resolved round-robin.
module ram16x8_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state;
  logic gnt;
  logic win;
`ifdef RAM_ARB_FIXED_PRIO_EN
  assign win = ~p0_req;
`else
  logic last;
  // on a tie the port not served last wins; a lone request always wins
  assign win = (p0_req && p1_req) ? ~last : p1_req;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      busy      <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      p0_done   <= 1'b0;
      p1_done   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last      <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (p0_req || p1_req) begin
          state     <= ISSUE;
          busy      <= 1'b1;
          gnt       <= win;
          ram_addr  <= win ? p1_addr : p0_addr;
          ram_we    <= win & p1_we;
          ram_wdata <= win ? p1_wdata : '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
          last      <= win;
`endif
        end
        ISSUE: begin
          // RAM samples the strobe on this edge, so it is exactly one cycle wide
          state  <= CAPTURE;
          ram_we <= 1'b0;
        end
        CAPTURE: begin
          state <= RESP;
          if (gnt) begin
            p1_rdata <= ram_rdata;
            p1_done  <= 1'b1;
          end else begin
            p0_rdata <= ram_rdata;
            p0_done  <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          p0_done <= 1'b0;
          p1_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram16x8_arbiter.sv
// tb_ram16x8_arbiter: directed bench with a transaction-level reference model and per-cycle compare.
module tb_ram16x8_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p0_req = 1'b0;
  logic [3:0] p0_addr = '0;
  logic [7:0] p0_rdata;
  logic       p0_done;
  logic       p1_req = 1'b0;
  logic       p1_we = 1'b0;
  logic [3:0] p1_addr = '0;
  logic [7:0] p1_wdata = '0;
  logic [7:0] p1_rdata;
  logic       p1_done;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       busy;
  int total = 0;
  int bad = 0;
  ram16x8_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_rdata(p0_rdata), .p0_done(p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_done(p1_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );
  always #5 clk = ~clk;
  // ram16x8 stand-in: synchronous read, read-before-write
  logic [7:0] mem [16];
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  // reference model: one access = grant at edge s, RAM access at s+1, data/done at s+2, idle from s+3
  int cyc = 0;
  int s = 0;
  bit act = 0;
  bit mw = 0;
  bit mwe = 0;
  bit mlast = 1;
  logic [3:0] maddr = '0;
  logic [7:0] mwd = '0;
  logic [7:0] pend = '0;
  logic [7:0] exp_r0 = '0;
  logic [7:0] exp_r1 = '0;
  logic [7:0] gold [16];
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      act = 0;
      exp_r0 = '0;
      exp_r1 = '0;
      mlast = 1;
    end else begin
      cyc++;
      if (act && cyc == s + 1) begin
        pend = gold[maddr];
        if (mwe) gold[maddr] = mwd;
      end
      if (act && cyc == s + 2) begin
        if (mw) exp_r1 = pend;
        else exp_r0 = pend;
      end
      if (act && cyc >= s + 4) act = 0;
      if (!act && (p0_req || p1_req)) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        mw = !p0_req;
`else
        if (p0_req && p1_req) mw = !mlast;
        else mw = p1_req;
`endif
        mlast = mw;
        act = 1;
        s = cyc;
        maddr = mw ? p1_addr : p0_addr;
        mwe = mw && p1_we;
        mwd = mw ? p1_wdata : 8'h00;
      end
    end
  end
  int idle_cnt = 0;
  int we_cnt = 0;
  initial forever begin
    int k;
    @(negedge clk);
    k = cyc - s;
    chk("busy", busy, act && k <= 2);
    chk("p0_done", p0_done, act && k == 2 && !mw);
    chk("p1_done", p1_done, act && k == 2 && mw);
    chk("ram_we", ram_we, act && k == 0 && mwe);
    chk("p0_rdata", p0_rdata, exp_r0);
    chk("p1_rdata", p1_rdata, exp_r1);
    if (act && k <= 1) begin
      chk("ram_addr", ram_addr, maddr);
      chk("ram_wdata", ram_wdata, mwd);
    end
    if (rst_n && !busy) idle_cnt++;
    if (ram_we) we_cnt++;
  end
  // one complete access; called and returns at posedge+1
  task automatic acc(input bit port, input bit we, input logic [3:0] a, input logic [7:0] wd,
                     input logic [7:0] e, input string nm);
    int t0;
    bit got;
    got = 0;
    if (port) begin
      p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = wd;
    end else begin
      p0_req = 1; p0_addr = a;
    end
    t0 = cyc;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (port ? p1_done : p0_done) got = 1;
    end
    if (!got) begin
      bad++; total++;
      $display("FAIL %s: done never seen, expected within 12 cycles", nm);
    end else begin
      chk(nm, port ? p1_rdata : p0_rdata, e);
      chk({nm, "_lat"}, cyc - t0, 3);
    end
    @(posedge clk); #1;
    if (port) begin p1_req = 0; p1_we = 0; end
    else p0_req = 0;
  endtask
  task automatic wait_done(input bit port, input string nm, output int c);
    bit got;
    got = 0;
    c = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (port ? p1_done : p0_done) begin got = 1; c = cyc; end
    end
    if (!got) begin
      bad++; total++;
      $display("FAIL %s: done never seen, expected within 12 cycles", nm);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t0, w0, i0, c0, c1, seen;
    logic [7:0] lit;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'h41 + 8'(i);
      gold[i] = 8'h41 + 8'(i);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_p0_done", p0_done, 0);
    chk("rst_p1_done", p1_done, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    rst_n = 1;
    @(posedge clk); #1;
    w0 = we_cnt;
    acc(0, 0, 4'h3, 8'h00, 8'h44, "rd3");
    chk("rd3_no_we", we_cnt - w0, 0);
    t0 = cyc;
    i0 = idle_cnt;
    for (int i = 0; i < 17; i++) begin
      lit = 8'h41 + 8'(i % 16);
      acc(0, 0, 4'(i % 16), 8'h00, lit, "fetch");
    end
    chk("fetch_cycles", cyc - t0, 68);
    chk("fetch_idle", idle_cnt - i0, 17);
    w0 = we_cnt;
    acc(1, 1, 4'h1, 8'h5A, 8'h42, "wr1_old");
    chk("wr1_we_width", we_cnt - w0, 1);
    acc(0, 0, 4'h1, 8'h00, 8'h5A, "rd1_new");
    p0_req = 1; p0_addr = 4'h4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    p1_req = 1; p1_we = 0; p1_addr = 4'h7;
    wait_done(0, "late_p0", c0);
    chk("late_p0_rdata", p0_rdata, 8'h45);
    @(posedge clk); #1;
    p0_req = 0;
    wait_done(1, "late_p1", c1);
    chk("late_p1_rdata", p1_rdata, 8'h48);
    chk("late_gap", c1 - c0, 4);
    @(posedge clk); #1;
    p1_req = 0;
    p1_req = 1; p1_we = 1; p1_addr = 4'h2; p1_wdata = 8'hFF;
    @(posedge clk); #1;
    chk("abort_we_issued", ram_we, 1);
    rst_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ram_we", ram_we, 0);
    chk("abort_ram_addr", ram_addr, 0);
    chk("abort_ram_wdata", ram_wdata, 0);
    chk("abort_p0_rdata", p0_rdata, 0);
    chk("abort_p1_rdata", p1_rdata, 0);
    chk("abort_p1_done", p1_done, 0);
    p1_req = 0; p1_we = 0; p1_wdata = 8'h00;
    @(posedge clk); #1;
    rst_n = 1;
    acc(0, 0, 4'h2, 8'h00, 8'h43, "rd2_after_abort");
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    p0_req = 1; p0_addr = 4'h5;
    p1_req = 1; p1_we = 0; p1_addr = 4'h6;
    for (int n = 0; n < 4; n++) begin
      seen = 2;
      for (int i = 0; i < 12 && seen == 2; i++) begin
        @(negedge clk);
        if (p0_done) seen = 0;
        else if (p1_done) seen = 1;
      end
`ifdef RAM_ARB_FIXED_PRIO_EN
      chk("contend_grant", seen, 0);
`else
      chk("contend_grant", seen, n % 2);
`endif
    end
    chk("contend_p0_rdata", p0_rdata, 8'h46);
    @(posedge clk); #1;
    p0_req = 0; p1_req = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
